// File: rtl/ntt_iter_core.sv
// ntt_iter_core: serial-in, in-place iterative radix-2 NTT/INTT over Z_Q with natural-order streaming output
module ntt_iter_core #(
    parameter int N        = 16,
    parameter int LOGN     = 4,
    parameter int W        = 16,
    parameter int Q        = 17,
    parameter int ROOT     = 3,
    parameter int ROOT_INV = 6,
    parameter int N_INV    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);
    localparam int HB = LOGN - 1;
    localparam int SW = $clog2(LOGN + 1);
    localparam logic [W-1:0]   QN = W'(Q);
    localparam logic [2*W-1:0] Q2 = (2*W)'(Q);
    localparam logic [W-1:0]   NI = W'(N_INV);

    function automatic logic [N/2*W-1:0] gen_tw(input longint r);
        logic [N/2*W-1:0] t;
        longint p;
        t = '0;
        p = 1;
        for (int e = 0; e < N/2; e++) begin
            t[e*W +: W] = W'(p);
            p = (p * r) % longint'(Q);
        end
        return t;
    endfunction

    localparam logic [N/2*W-1:0] TW_F = gen_tw(longint'(ROOT));
    localparam logic [N/2*W-1:0] TW_I = gen_tw(longint'(ROOT_INV));

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return W'(p % Q2);
    endfunction

    function automatic logic [LOGN-1:0] rev(input logic [LOGN-1:0] i);
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) r[b] = i[LOGN-1-b];
        return r;
    endfunction

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

    state_t state_q, state_d;
    logic [LOGN-1:0] cnt_q, cnt_d;
    logic [SW-1:0] st_q, st_d;
    logic [HB-1:0] t_q, t_d;
    logic mode_q, mode_d;
    logic [W-1:0] a_q [N];

    logic in_fire, last_bf;
    logic [SW-1:0] sh;
    logic [HB-1:0] msk, jj, gg, e;
    logic [LOGN-1:0] top, bot;
    logic [W-1:0] w, u, v, sum, diff;
    logic [W:0] s;

    assign in_ready  = rst & (state_q == S_LOAD);
    assign in_fire   = in_valid & in_ready;
    assign out_valid = state_q == S_UNLOAD;
    assign out_last  = out_valid & (&cnt_q);
    assign busy      = state_q != S_LOAD;
    assign out_data  = out_valid ? (mode_q ? mulmod(a_q[cnt_q], NI) : a_q[cnt_q]) : '0;
    assign last_bf   = (st_q == SW'(HB)) & (&t_q);

    // Butterfly address/twiddle decode: t = j*(N/m) + k/m, so its high bits give the twiddle exponent
    always_comb begin
        sh   = SW'(HB) - st_q;
        msk  = {HB{1'b1}} >> st_q;
        gg   = t_q & msk;
        e    = t_q & ~msk;
        jj   = t_q >> sh;
        top  = ({1'b0, gg} << (st_q + 1'b1)) | {1'b0, jj};
        bot  = top | (LOGN'(1) << st_q);
        w    = mode_q ? TW_I[e*W +: W] : TW_F[e*W +: W];
        u    = a_q[top];
        v    = mulmod(a_q[bot], w);
        s    = {1'b0, u} + {1'b0, v};
        sum  = W'(s >= {1'b0, QN} ? s - {1'b0, QN} : s);
        diff = u >= v ? u - v : QN - v + u;
    end

    // Next-state logic for the LOAD -> COMPUTE -> UNLOAD frame sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        t_d     = t_q;
        mode_d  = mode_q;
        case (state_q)
            S_LOAD: if (in_fire) begin
                mode_d  = cnt_q == '0 ? mode : mode_q;
                cnt_d   = cnt_q + 1'b1;
                state_d = &cnt_q ? S_COMPUTE : S_LOAD;
            end
            S_COMPUTE: begin
                t_d     = t_q + 1'b1;
                st_d    = last_bf ? '0 : (&t_q ? st_q + 1'b1 : st_q);
                state_d = last_bf ? S_UNLOAD : S_COMPUTE;
            end
            S_UNLOAD: if (out_ready) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = &cnt_q ? S_LOAD : S_UNLOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Control registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            st_q    <= '0;
            t_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            t_q     <= t_d;
            mode_q  <= mode_d;
        end
    end

    // Coefficient array: bit-reversed load, then one in-place butterfly per COMPUTE cycle
    always_ff @(posedge clk) begin
        if (in_fire) begin
            a_q[rev(cnt_q)] <= W'(in_data % QN);
        end else if (state_q == S_COMPUTE) begin
            a_q[top] <= sum;
            a_q[bot] <= diff;
        end
    end
endmodule

// File: tb/tb_ntt_iter_core.sv
// tb_ntt_iter_core: directed checks of the iterative NTT core against hand-computed vectors
module tb_ntt_iter_core;
    localparam int N = 16;
    localparam int W = 16;

    typedef logic [W-1:0] vec_t [N];

    logic clk = 0;
    logic rst = 0;
    logic mode = 0;
    logic in_valid = 0;
    logic in_ready;
    logic [W-1:0] in_data = '0;
    logic out_valid;
    logic out_ready = 0;
    logic [W-1:0] out_data;
    logic out_last;
    logic busy;

    int total = 0;
    int passes = 0;
    int cyc;

    vec_t vx    = '{15, 2, 16, 10, 7, 5, 6, 16, 10, 4, 0, 5, 8, 11, 2, 8};
    vec_t vy    = '{6, 9, 8, 8, 16, 8, 15, 15, 3, 9, 16, 2, 16, 10, 1, 13};
    vec_t delta = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec_t ones  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    vec_t zero  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    ntt_iter_core dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic load(input logic md, input vec_t v);
        for (int i = 0; i < N; i++) begin
            int g = 0;
            mode = md;
            in_valid = 1;
            in_data = v[i];
            while (!in_ready && g < 200) begin
                @(posedge clk); #1;
                g++;
            end
            chk("load_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 0;
    endtask

    task automatic collect(input vec_t x, input bit bp);
        for (int i = 0; i < N; i++) begin
            int g = 0;
            if (bp && i == 7) begin
                out_ready = 0;
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("stall_data", out_data, x[7]);
                end
            end
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            while (!(out_valid && out_ready) && g < 300) begin
                if (out_valid) chk("hold_data", out_data, x[i]);
                @(posedge clk); #1;
                g++;
                out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, x[i]);
            chk("out_last", out_last, i == N - 1);
            @(posedge clk); #1;
        end
        out_ready = 0;
        chk("done_valid", out_valid, 0);
        chk("done_busy", busy, 0);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        #21 rst = 1;
        #1;
        chk("post_rst_ready", in_ready, 1);

        load(0, vx);
        cyc = 1;
        chk("compute_busy", busy, 1);
        chk("compute_ready", in_ready, 0);
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, 33);
        collect(vy, 0);

        load(1, vy);
        collect(vx, 0);
        load(0, delta);
        collect(ones, 0);
        load(1, ones);
        collect(delta, 0);
        load(0, zero);
        collect(zero, 0);
        load(1, zero);
        collect(zero, 0);

        load(0, vx);
        collect(vy, 1);

        load(0, vx);
        repeat (10) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 0);
        @(posedge clk); #3 rst = 1;
        #1;
        chk("abort_ready_rel", in_ready, 1);
        chk("abort_busy_rel", busy, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_output", out_valid, 0);
        load(1, vy);
        collect(vx, 0);

        load(0, vx);
        in_valid = 1;
        in_data = vy[0];
        mode = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("b2b_refuse", in_ready, 0);
        collect(vy, 0);
        load(1, vy);
        collect(vx, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/ntt_iter_core.md
Name: ntt_iter_core

Overview:
- Parametrised, iterative, in-place radix-2 NTT/INTT engine over Z_Q. It is the sequential, streaming successor of the fixed 16-point combinational transform.
- Accepts N coefficients serially, then runs LOGN butterfly stages on an internal register array.
- Streams N results out in natural order.
- Direction is selected per frame: forward (unscaled) or inverse (scaled by N^-1). It sits between the polynomial buffer and the pointwise-multiply unit of the FHE datapath.

Parameters:
- N, 16, transform length (power of two, >= 4)
- LOGN, 4, log2(N)
- W, 16, data width
- Q, 17, prime modulus (Q < 2^W, N divides Q-1)
- ROOT, 3, primitive N-th root of unity mod Q
- ROOT_INV, 6, ROOT^-1 mod Q
- N_INV, 16, N^-1 mod Q

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  1  0 = forward NTT, 1 = inverse NTT; sampled on first accepted input beat of a frame
- in_valid  in  1  input beat valid
- in_ready  out  1  core can accept input
- in_data  in  W  input coefficient, natural order index 0..N-1
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- out_data  out  W  output coefficient, natural order
- out_last  out  1  high with index N-1 beat
- busy  out  1  high in COMPUTE or UNLOAD

Behaviour:
- Reset (rst low, async): state = LOAD, counters = 0, mode register = 0, in_ready = 0 during reset then 1. Outputs: out_valid = 0, out_last = 0, busy = 0, out_data = 0. Array contents are don't-care.
- States: LOAD -> COMPUTE -> UNLOAD -> LOAD.
- LOAD:
  - in_ready = 1; a beat transfers when in_valid & in_ready.
  - Beat i is stored at bit-reversed address rev(i) after reduction in_data mod Q.
  - mode is latched on beat 0.
  - After beat N-1, go to COMPUTE next cycle.
- COMPUTE:
  - in_ready = 0, busy = 1. Exactly one butterfly per cycle, (N/2)*LOGN cycles total (32 for defaults). No stalls.
  - Loop order: stage s = 1..LOGN, m = 2^s; j = 0..m/2-1; k = 0, m, 2m, .. < N.
  - Operands: u = A[k+j], v = A[k+j+m/2] * w mod Q.
  - Writes: A[k+j] = (u+v) mod Q; A[k+j+m/2] = (u-v) mod Q. Subtraction wraps by adding Q when u < v.
  - Twiddle w = T[j*(N/m)]. T[e] = ROOT^e (forward) or ROOT_INV^e (inverse) mod Q, e = 0..N/2-1.
  - Both tables are built at elaboration by a constant function; no runtime ROM load.
  - Product is 2W bits wide, reduced mod Q in the same cycle.
  - After the last butterfly, go to UNLOAD.
- UNLOAD:
  - out_valid = 1. out_data = A[idx] (forward) or A[idx]*N_INV mod Q (inverse).
  - idx advances only on out_valid & out_ready; out_data is held stable while out_ready is low.
  - out_last = 1 when idx = N-1. Its handshake returns to LOAD; in_ready rises the following cycle.
- Results are always in [0, Q-1].
- Latency from last input beat to first out_valid: (N/2)*LOGN + 1 cycles.
- in_valid during COMPUTE/UNLOAD is ignored (no transfer).
- mode changes mid-frame have no effect.
- Reset mid-operation aborts the frame immediately; no partial output is emitted afterward.

Test Plan:
- Forward, mode=0, input [15,2,16,10,7,5,6,16,10,4,0,5,8,11,2,8] -> outputs [6,9,8,8,16,8,15,15,3,9,16,2,16,10,1,13]; out_last on 16th beat; first out_valid exactly 33 cycles after last input beat.
- Inverse, mode=1, input [6,9,8,8,16,8,15,15,3,9,16,2,16,10,1,13] -> recovers [15,2,16,10,7,5,6,16,10,4,0,5,8,11,2,8].
- Delta/constant: forward of [1,0,...,0] -> sixteen 1s; inverse of sixteen 1s -> [1,0,...,0]. All-zero input gives all zeros in both modes.
- Backpressure: out_ready toggled randomly and held low for 5 cycles at idx 7 -> out_data stable while stalled, no beat lost or duplicated, sequence matches the forward vector.
- Reset mid-COMPUTE: drive rst low at butterfly 10 -> out_valid = 0, busy = 0, in_ready = 1 after release. A fresh inverse frame then completes correctly.
- Back-to-back frames: forward immediately followed by inverse with in_valid held high -> input is refused during COMPUTE/UNLOAD, both results are correct, and the second frame's mode is honoured.
